conv_kernel_pos_ctrl: RTL and testbench
=======================================

CONV_KERNEL_POS_CTRL -- requirements
Module: conv_kernel_pos_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  COL_W  conv_pkg::COL_W  width of frame column count/index
  ROW_W  conv_pkg::ROW_W  width of frame row count/index
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk  in  1  sole clock, rising edge
  arst_n  in  1  asynchronous active-low reset
  cfg_width_i  in  COL_W  frame width in pixels, 1..2^COL_W-1
  cfg_height_i  in  ROW_W  frame height in rows, 1..2^ROW_W-1
  in_vld_i  in  1  upstream pixel beat valid
  in_sof_i  in  1  upstream start-of-frame marker
  in_rdy_o  out  1  beat accepted when in_vld_i & in_rdy_o
  out_vld_o  out  1  position beat valid
  out_rdy_i  in  1  downstream ready
  out_pos_o  out  kernel_pos_t  n1/n2/s1/s2/w1/w2/e1/e2 edge flags for the zero-pad mask
  out_sof_o / out_eol_o / out_eof_o  out  1 each  first pixel / last column / last pixel of frame
  busy_o  out  1  frame in progress
  err_o  out  1  sticky framing error

Function
REQ-003 SHALL be a one-stage registered pipeline: in_rdy_o = ~out_vld_o | out_rdy_i; 1-cycle latency; 1 beat/cycle sustained.
REQ-004 SHALL hold out_pos_o/markers stable while out_vld_o & ~out_rdy_i.
REQ-005 SHALL implement FSM IDLE/ACTIVE: IDLE->ACTIVE on first accepted beat (latch cfg_width_i/cfg_height_i, row=col=0); ACTIVE->IDLE on accepting the beat at (H-1,W-1).
REQ-006 SHALL ignore cfg_* changes while ACTIVE; busy_o = (state==ACTIVE).
REQ-007 SHALL advance col per accepted beat; at col==W-1 wrap col to 0 and increment row.
REQ-008 SHALL compute flags of the accepted beat's (row,col): n2=row==0; n1=row==1; s2=row==H-1; s1=row==H-2 & H>=2; w2=col==0; w1=col==1; e2=col==W-1; e1=col==W-2 & W>=2.
REQ-009 SHALL keep n1/n2 mutually exclusive, same for s, w, e pairs; pairs from opposite sides may coexist (H=1 -> n2&s2 on every beat; W=1 -> w2&e2).
REQ-010 SHALL assert out_sof_o at (0,0), out_eol_o at col==W-1, out_eof_o at (H-1,W-1); W=H=1 -> all three on one beat, FSM stays IDLE.
REQ-011 SHALL accept a back-to-back frame on the cycle after the eof beat is accepted (no bubble).

Reset
REQ-012 SHALL, on arst_n low (any cycle, incl. mid-frame): state=IDLE, out_vld_o=0, out_pos_o=0, all markers=0, busy_o=0, err_o=0, counters=0, latched dims=0.
REQ-013 SHALL resume by treating the first post-reset beat as (0,0) of a new frame.

Configuration
REQ-014 SHALL, with CONV_KERNEL_POS_CTRL_ERR_EN defined, set err_o sticky when an accepted beat has in_sof_i=1 in ACTIVE or in_sof_i=0 in IDLE; position tracking unaffected (no resync); clear only by reset.
REQ-015 SHALL, without CONV_KERNEL_POS_CTRL_ERR_EN, ignore in_sof_i and tie err_o to 0.

Structure
REQ-016 SHALL take kernel_pos_t, COL_W, ROW_W and the FSM state enum from conv_pkg.
REQ-017 SHALL place row/col counting, wrap and last-detect in one sub-module conv_pos_cnt; flag decode, FSM and output register stay in the top.

Verification
REQ-018 W=5,H=4, continuous valid/ready -> 20 beats; beat0 n2&w2&sof; beat6 (1,1) n1&w1; beat19 s2&e2&eof; busy_o falls after beat19.
REQ-019 W=1,H=1 -> one beat with n2,s2,w2,e2,sof,eol,eof all 1; FSM never leaves IDLE.
REQ-020 W=3,H=3, out_rdy_i 0 for 4 cycles at beat4 -> in_rdy_o=0, out_pos_o unchanged during stall; beat4 center (1,1) has n1,s1,w1,e1 only.
REQ-021 Two 4x2 frames back-to-back, cfg changed to 2x2 mid-frame1 -> frame1 keeps 4x2 flags; frame2 uses 2x2; no idle cycle between.
REQ-022 arst_n pulsed after beat 7 of a 5x4 frame -> outputs 0 immediately; next beat reported as (0,0) with sof.
REQ-023 ERR_EN build: in_sof_i=1 on beat 3 of a frame -> err_o=1 from next cycle, stays 1; flags continue as (0,3),(0,4)...; non-ERR_EN build: err_o stays 0.

Source files
------------

// File: rtl/conv_pkg.sv
// ============================================================================
// Module   : conv_pkg
// Purpose  : Shared types and widths for the convolution kernel position path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

  localparam int COL_W = 8;
  localparam int ROW_W = 8;

  // Edge flags: *2 = outermost row/column, *1 = one pixel in from that edge
  typedef struct packed {
    logic n1;
    logic n2;
    logic s1;
    logic s2;
    logic w1;
    logic w2;
    logic e1;
    logic e2;
  } kernel_pos_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } pos_state_e;

endpackage

`default_nettype wire

// File: rtl/conv_pos_cnt.sv
// ============================================================================
// Module   : conv_pos_cnt
// Purpose  : Row/column position counter with wrap and last-pixel detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_pos_cnt #(
  parameter int COL_W = conv_pkg::COL_W,
  parameter int ROW_W = conv_pkg::ROW_W
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             adv_i,
  input  logic [COL_W-1:0] width_i,
  input  logic [ROW_W-1:0] height_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             last_col_o,
  output logic             last_row_o,
  output logic             last_o
);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             w_last_col;
  logic             w_last_row;

  assign w_last_col = (r_col == width_i - COL_W'(1));
  assign w_last_row = (r_row == height_i - ROW_W'(1));

  // Counters return to zero after the last pixel, so IDLE always sees (0,0)
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (adv_i) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign col_o      = r_col;
  assign row_o      = r_row;
  assign last_col_o = w_last_col;
  assign last_row_o = w_last_row;
  assign last_o     = w_last_col & w_last_row;

endmodule

`default_nettype wire

// File: rtl/conv_kernel_pos_ctrl.sv
// ============================================================================
// Module   : conv_kernel_pos_ctrl
// Purpose  : Tags each pixel beat with kernel edge flags and frame markers.
//            Optional macro CONV_KERNEL_POS_CTRL_ERR_EN enables sof checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_kernel_pos_ctrl
  import conv_pkg::*;
#(
  parameter int COL_W = conv_pkg::COL_W,
  parameter int ROW_W = conv_pkg::ROW_W
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [COL_W-1:0] cfg_width_i,
  input  logic [ROW_W-1:0] cfg_height_i,
  input  logic             in_vld_i,
  input  logic             in_sof_i,
  output logic             in_rdy_o,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output kernel_pos_t      out_pos_o,
  output logic             out_sof_o,
  output logic             out_eol_o,
  output logic             out_eof_o,
  output logic             busy_o,
  output logic             err_o
);

  pos_state_e       r_state;
  pos_state_e       w_state_nxt;
  logic [COL_W-1:0] r_width;
  logic [ROW_W-1:0] r_height;
  logic [COL_W-1:0] w_width;
  logic [ROW_W-1:0] w_height;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic             w_last_col;
  logic             w_last_row;
  logic             w_last;
  logic             w_idle;
  logic             w_accept;
  kernel_pos_t      w_pos;
  logic             r_vld;
  kernel_pos_t      r_pos;
  logic             r_sof;
  logic             r_eol;
  logic             r_eof;

  assign w_idle   = (r_state == ST_IDLE);
  assign in_rdy_o = ~r_vld | out_rdy_i;
  assign w_accept = in_vld_i & in_rdy_o;

  // In IDLE the live config applies to the first beat; afterwards the latched copy
  assign w_width  = w_idle ? cfg_width_i  : r_width;
  assign w_height = w_idle ? cfg_height_i : r_height;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_width  <= '0;
      r_height <= '0;
    end else if (w_accept && w_idle) begin
      r_width  <= cfg_width_i;
      r_height <= cfg_height_i;
    end
  end

  conv_pos_cnt #(
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_pos_cnt (
    .clk        (clk),
    .arst_n     (arst_n),
    .adv_i      (w_accept),
    .width_i    (w_width),
    .height_i   (w_height),
    .col_o      (w_col),
    .row_o      (w_row),
    .last_col_o (w_last_col),
    .last_row_o (w_last_row),
    .last_o     (w_last)
  );

  always_comb begin
    w_pos    = '0;
    w_pos.n2 = (w_row == '0);
    w_pos.n1 = (w_row == ROW_W'(1));
    w_pos.s2 = w_last_row;
    w_pos.s1 = (w_height >= ROW_W'(2)) && (w_row == w_height - ROW_W'(2));
    w_pos.w2 = (w_col == '0);
    w_pos.w1 = (w_col == COL_W'(1));
    w_pos.e2 = w_last_col;
    w_pos.e1 = (w_width >= COL_W'(2)) && (w_col == w_width - COL_W'(2));
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy_o      = (r_state == ST_ACTIVE);
    case (r_state)
      ST_IDLE:   if (w_accept && !w_last) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (w_accept && w_last)  w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_vld <= 1'b0;
      r_pos <= '0;
      r_sof <= 1'b0;
      r_eol <= 1'b0;
      r_eof <= 1'b0;
    end else if (w_accept) begin
      r_vld <= 1'b1;
      r_pos <= w_pos;
      r_sof <= w_pos.n2 & w_pos.w2;
      r_eol <= w_last_col;
      r_eof <= w_last;
    end else if (out_rdy_i) begin
      r_vld <= 1'b0;
    end
  end

  assign out_vld_o = r_vld;
  assign out_pos_o = r_pos;
  assign out_sof_o = r_sof;
  assign out_eol_o = r_eol;
  assign out_eof_o = r_eof;

`ifdef CONV_KERNEL_POS_CTRL_ERR_EN
  logic r_err;

  // Flags a marker that disagrees with the tracked frame state; no resync
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_err <= 1'b0;
    end else if (w_accept && (in_sof_i != w_idle)) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_sof;

  assign w_unused_sof = in_sof_i;
  assign err_o        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_kernel_pos_ctrl.sv
// ============================================================================
// Module   : tb_conv_kernel_pos_ctrl
// Purpose  : Scoreboard bench for conv_kernel_pos_ctrl position tagging.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_kernel_pos_ctrl;
  import conv_pkg::*;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic [COL_W-1:0] cfg_width_i = '0;
  logic [ROW_W-1:0] cfg_height_i = '0;
  logic             in_vld_i = 1'b0;
  logic             in_sof_i = 1'b0;
  logic             in_rdy_o;
  logic             out_vld_o;
  logic             out_rdy_i = 1'b1;
  kernel_pos_t      out_pos_o;
  logic             out_sof_o;
  logic             out_eol_o;
  logic             out_eof_o;
  logic             busy_o;
  logic             err_o;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [10:0] sb[$];

`ifdef CONV_KERNEL_POS_CTRL_ERR_EN
  localparam logic c_err_exp = 1'b1;
`else
  localparam logic c_err_exp = 1'b0;
`endif

  conv_kernel_pos_ctrl dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .cfg_width_i  (cfg_width_i),
    .cfg_height_i (cfg_height_i),
    .in_vld_i     (in_vld_i),
    .in_sof_i     (in_sof_i),
    .in_rdy_o     (in_rdy_o),
    .out_vld_o    (out_vld_o),
    .out_rdy_i    (out_rdy_i),
    .out_pos_o    (out_pos_o),
    .out_sof_o    (out_sof_o),
    .out_eol_o    (out_eol_o),
    .out_eof_o    (out_eof_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {n1,n2,s1,s2,w1,w2,e1,e2,sof,eol,eof} for pixel (r,c) of a w x h frame
  function automatic logic [10:0] exp_beat(input int r, input int c, input int w, input int h);
    exp_beat = {r == 1, r == 0, (h >= 2) && (r == h - 2), r == h - 1,
                c == 1, c == 0, (w >= 2) && (c == w - 2), c == w - 1,
                (r == 0) && (c == 0), c == w - 1, (r == h - 1) && (c == w - 1)};
  endfunction

  task automatic monitor();
    logic [10:0] got;
    logic [10:0] exp;
    forever begin
      @(negedge clk);
      if (arst_n && out_vld_o && out_rdy_i) begin
        got = {out_pos_o, out_sof_o, out_eol_o, out_eof_o};
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL out_beat: got unexpected beat %b, required none", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) $display("FAIL out_beat: got %b required %b", got, exp);
          else n_pass++;
        end
      end
    end
  endtask

  // Leaves in_vld_i high; caller changes it without letting time pass
  task automatic send_beat(input logic sof, input logic [10:0] exp);
    int   guard;
    logic ok;
    in_vld_i = 1'b1;
    in_sof_i = sof;
    sb.push_back(exp);
    guard = 0;
    ok    = 1'b0;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = in_rdy_o;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL send_beat: in_rdy_o=%b required 1 within 200 cycles", in_rdy_o);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    n_checks++;
    if (sb.size() != 0) $display("FAIL drain: %0d beats outstanding, required 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    cfg_width_i  = COL_W'(5);
    cfg_height_i = ROW_W'(4);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_vld_o, out_pos_o, out_sof_o, out_eol_o, out_eof_o, busy_o, err_o} !== 14'd0)
      $display("FAIL reset_outputs: got %b required 0",
               {out_vld_o, out_pos_o, out_sof_o, out_eol_o, out_eof_o, busy_o, err_o});
    else n_pass++;
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({in_rdy_o, out_vld_o, busy_o} !== 3'b100)
      $display("FAIL post_reset: rdy/vld/busy got %b required 100", {in_rdy_o, out_vld_o, busy_o});
    else n_pass++;
  endtask

  task automatic test_frame_5x4();
    cfg_width_i  = COL_W'(5);
    cfg_height_i = ROW_W'(4);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 5; c++) begin
        send_beat(r == 0 && c == 0, exp_beat(r, c, 5, 4));
        if (r == 0 && c == 0) begin
          n_checks++;
          if (busy_o !== 1'b1) $display("FAIL busy_rise: got %b required 1", busy_o);
          else n_pass++;
        end
      end
    end
    in_vld_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL busy_fall: got %b required 0", busy_o);
    else n_pass++;
    drain();
  endtask

  task automatic test_single_pixel();
    cfg_width_i  = COL_W'(1);
    cfg_height_i = ROW_W'(1);
    send_beat(1'b1, exp_beat(0, 0, 1, 1));
    in_vld_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL single_idle: busy got %b required 0", busy_o);
    else n_pass++;
    drain();
  endtask

  task automatic test_stall();
    cfg_width_i  = COL_W'(3);
    cfg_height_i = ROW_W'(3);
    for (int b = 0; b < 5; b++) send_beat(b == 0, exp_beat(b / 3, b % 3, 3, 3));
    out_rdy_i = 1'b0;
    in_sof_i  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_rdy_o !== 1'b0) $display("FAIL stall_rdy: got %b required 0", in_rdy_o);
      else n_pass++;
      n_checks++;
      if ({out_vld_o, out_pos_o, out_sof_o, out_eol_o, out_eof_o} !== 12'b1_10101010_000)
        $display("FAIL stall_hold: got %b required 110101010000",
                 {out_vld_o, out_pos_o, out_sof_o, out_eol_o, out_eof_o});
      else n_pass++;
    end
    @(posedge clk);
    #1;
    out_rdy_i = 1'b1;
    for (int b = 5; b < 9; b++) send_beat(1'b0, exp_beat(b / 3, b % 3, 3, 3));
    in_vld_i = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    int c0;
    cfg_width_i  = COL_W'(4);
    cfg_height_i = ROW_W'(2);
    c0 = cyc;
    for (int b = 0; b < 8; b++) begin
      send_beat(b == 0, exp_beat(b / 4, b % 4, 4, 2));
      if (b == 3) begin
        cfg_width_i  = COL_W'(2);
        cfg_height_i = ROW_W'(2);
      end
    end
    for (int b = 0; b < 4; b++) send_beat(b == 0, exp_beat(b / 2, b % 2, 2, 2));
    in_vld_i = 1'b0;
    n_checks++;
    if (cyc - c0 !== 12) $display("FAIL b2b_cycles: got %0d required 12", cyc - c0);
    else n_pass++;
    drain();
  endtask

  task automatic test_async_reset();
    cfg_width_i  = COL_W'(5);
    cfg_height_i = ROW_W'(4);
    for (int b = 0; b < 8; b++) send_beat(b == 0, exp_beat(b / 5, b % 5, 5, 4));
    in_vld_i  = 1'b0;
    out_rdy_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_vld_o, busy_o} !== 2'b11) $display("FAIL pre_reset: vld/busy got %b required 11", {out_vld_o, busy_o});
    else n_pass++;
    #2;
    arst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_vld_o, out_pos_o, out_sof_o, out_eol_o, out_eof_o, busy_o, err_o} !== 14'd0)
      $display("FAIL async_reset: got %b required 0",
               {out_vld_o, out_pos_o, out_sof_o, out_eol_o, out_eof_o, busy_o, err_o});
    else n_pass++;
    sb.delete();
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    out_rdy_i = 1'b1;
    for (int b = 0; b < 20; b++) send_beat(b == 0, exp_beat(b / 5, b % 5, 5, 4));
    in_vld_i = 1'b0;
    drain();
  endtask

  task automatic test_sof_error();
    cfg_width_i  = COL_W'(6);
    cfg_height_i = ROW_W'(2);
    n_checks++;
    if (err_o !== 1'b0) $display("FAIL err_clean: got %b required 0", err_o);
    else n_pass++;
    for (int b = 0; b < 12; b++) begin
      send_beat(b == 0 || b == 3, exp_beat(b / 6, b % 6, 6, 2));
      if (b == 3) begin
        in_vld_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err_o !== c_err_exp) $display("FAIL err_set: got %b required %b", err_o, c_err_exp);
        else n_pass++;
        @(posedge clk);
        #1;
      end
    end
    in_vld_i = 1'b0;
    drain();
    n_checks++;
    if (err_o !== c_err_exp) $display("FAIL err_sticky: got %b required %b", err_o, c_err_exp);
    else n_pass++;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_frame_5x4();
    test_single_pixel();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_sof_error();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
